// File: rtl/seq_mult_pkg.sv
// seq_mult_pkg
//   Shared definitions for the sequential shift-add multiplier:
//   FSM state encoding, default operand width and the iteration-counter
//   width helper.
package seq_mult_pkg;

  // Operand width used when the parent does not override WIDTH.
  localparam int SEQ_MULT_DEFAULT_WIDTH = 8;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed for a counter that must be able to hold the value `width`.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_mag.sv
// seq_mult_mag
//   Combinational conditional two's-complement negation. Used to take the
//   magnitude of a signed operand and to apply the sign to the final product.
//   Ports:
//     value  - input word
//     negate - 1: result = -value, 0: result = value
//     result - output word (same width as value)
module seq_mult_mag
  import seq_mult_pkg::*;
#(
  parameter int W = SEQ_MULT_DEFAULT_WIDTH
) (
  input  logic [W-1:0] value,
  input  logic         negate,
  output logic [W-1:0] result
);

  // Invert-and-increment when negation is requested, pass-through otherwise.
  always_comb begin
    if (negate) begin
      result = (~value) + {{(W-1){1'b0}}, 1'b1};
    end else begin
      result = value;
    end
  end

endmodule

// File: rtl/seq_mult.sv
// seq_mult
//   Radix-2 sequential shift-add multiplier with start/busy handshake and a
//   per-operation signed/unsigned mode. Signed operands are converted to
//   magnitudes on capture; the sign is re-applied when the result is stored.
//   Parameters:
//     WIDTH - operand width (>= 2); the product is 2*WIDTH bits
//   Ports:
//     CLK       - rising-edge clock
//     reset     - synchronous active-high reset, aborts any operation
//     start     - request, accepted when busy == 0
//     in_signed - 1: two's-complement operands, 0: unsigned (sampled with start)
//     in_a      - multiplicand (sampled with start)
//     in_b      - multiplier (sampled with start)
//     out       - product, held until the next result
//     out_valid - one-cycle strobe on the cycle out is updated
//     busy      - high while an operation is in progress
//   Build option:
//     SEQ_MULT_EARLY_TERM_EN - finish as soon as the remaining multiplier
//                              is zero instead of always iterating WIDTH times
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = SEQ_MULT_DEFAULT_WIDTH
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = cnt_width(WIDTH);

  state_t             state_r;
  state_t             next_state_s;
  logic [PW-1:0]      mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [PW-1:0]      acc_r;
  logic [CW-1:0]      cnt_r;
  logic               sign_r;
  logic [PW-1:0]      out_r;
  logic               out_valid_r;
  logic               busy_r;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [PW-1:0]      res_s;
  logic               calc_last_s;

  // |a| in signed mode; the most-negative value maps onto 2^(WIDTH-1), which
  // still fits as an unsigned WIDTH-bit magnitude.
  seq_mult_mag #(.W(WIDTH)) u_mag_a (
    .value  (in_a),
    .negate (in_signed & in_a[WIDTH-1]),
    .result (a_mag_s)
  );

  seq_mult_mag #(.W(WIDTH)) u_mag_b (
    .value  (in_b),
    .negate (in_signed & in_b[WIDTH-1]),
    .result (b_mag_s)
  );

  // Sign is applied to the unsigned accumulator; a zero accumulator negates
  // to zero, so -0 never appears.
  seq_mult_mag #(.W(PW)) u_mag_res (
    .value  (acc_r),
    .negate (sign_r),
    .result (res_s)
  );

  // Decide whether the current CALC edge stores the result instead of iterating.
  always_comb begin
`ifdef SEQ_MULT_EARLY_TERM_EN
    calc_last_s = (cnt_r == CW'(WIDTH)) || (mplier_r == {WIDTH{1'b0}});
`else
    calc_last_s = (cnt_r == CW'(WIDTH));
`endif
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; DONE accepts a new start just like IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) next_state_s = CALC;
        else       next_state_s = IDLE;
      end
      CALC: begin
        if (calc_last_s) next_state_s = DONE;
        else             next_state_s = CALC;
      end
      DONE: begin
        if (start) next_state_s = CALC;
        else       next_state_s = IDLE;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Operand capture, shift-add iteration and registered outputs.
  always_ff @(posedge CLK) begin
    if (reset) begin
      mcand_r     <= {PW{1'b0}};
      mplier_r    <= {WIDTH{1'b0}};
      acc_r       <= {PW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      sign_r      <= 1'b0;
      out_r       <= {PW{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      busy_r      <= (next_state_s == CALC);
      case (state_r)
        IDLE, DONE: begin
          if (start) begin
            mcand_r  <= {{WIDTH{1'b0}}, a_mag_s};
            mplier_r <= b_mag_s;
            acc_r    <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
            sign_r   <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
          end
        end
        CALC: begin
          if (calc_last_s) begin
            out_r       <= res_s;
            out_valid_r <= 1'b1;
          end else begin
            if (mplier_r[0]) begin
              acc_r <= acc_r + mcand_r;
            end
            mcand_r  <= {mcand_r[PW-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_seq_mult.sv
// tb_seq_mult
//   Self-checking bench for seq_mult. A cycle-level behavioural model
//   (pending operation + due cycle) predicts out/out_valid/busy every cycle
//   for the WIDTH=8 instance; directed operations pin product and latency
//   with literal values; a WIDTH=16 instance covers the wide corner cases.
module tb_seq_mult;

`ifdef SEQ_MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        reset;
  logic        start;
  logic        in_signed;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [15:0] out;
  logic        out_valid;
  logic        busy;

  logic        start16;
  logic        signed16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic [31:0] out16;
  logic        valid16;
  logic        busy16;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  bit          m_pending = 1'b0;
  int          m_due     = 0;
  logic [15:0] m_prod    = 16'h0;
  logic [15:0] m_out     = 16'h0;
  logic        m_valid   = 1'b0;
  logic        m_busy    = 1'b0;

  always #5 CLK = ~CLK;

  seq_mult #(.WIDTH(8)) u_dut (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start),
    .in_signed (in_signed),
    .in_a      (in_a),
    .in_b      (in_b),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  seq_mult #(.WIDTH(16)) u_dut16 (
    .CLK       (CLK),
    .reset     (reset),
    .start     (start16),
    .in_signed (signed16),
    .in_a      (a16),
    .in_b      (b16),
    .out       (out16),
    .out_valid (valid16),
    .busy      (busy16)
  );

  function automatic logic [15:0] ref_prod8(input logic s, input logic [7:0] a, input logic [7:0] b);
    int p;
    if (s) p = int'($signed(a)) * int'($signed(b));
    else   p = int'(a) * int'(b);
    return p[15:0];
  endfunction

  function automatic logic [31:0] ref_prod16(input logic s, input logic [15:0] a, input logic [15:0] b);
    longint p;
    if (s) p = longint'($signed(a)) * longint'($signed(b));
    else   p = longint'(a) * longint'(b);
    return p[31:0];
  endfunction

  // Latency in edges from the accepting edge to the result edge.
  function automatic int ref_lat(input int mag, input int w);
    int hi;
    if (!EARLY) return w + 1;
    if (mag == 0) return 1;
    hi = 0;
    for (int i = 0; i < w; i++) if (mag[i]) hi = i;
    return hi + 2;
  endfunction

  function automatic int mag8(input logic s, input logic [7:0] b);
    int v;
    v = s ? int'($signed(b)) : int'(b);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int mag16(input logic s, input logic [15:0] b);
    int v;
    v = s ? int'($signed(b)) : int'(b);
    return (v < 0) ? -v : v;
  endfunction

  // Behavioural model of the WIDTH=8 instance, advanced on every edge.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_pending <= 1'b0;
      m_out     <= 16'h0;
      m_valid   <= 1'b0;
      m_busy    <= 1'b0;
    end else if (m_pending && cyc == m_due) begin
      m_out     <= m_prod;
      m_valid   <= 1'b1;
      m_pending <= 1'b0;
      m_busy    <= 1'b0;
    end else if (!m_pending && start) begin
      m_pending <= 1'b1;
      m_busy    <= 1'b1;
      m_valid   <= 1'b0;
      m_prod    <= ref_prod8(in_signed, in_a, in_b);
      m_due     <= cyc + ref_lat(mag8(in_signed, in_b), 8);
    end else begin
      m_valid   <= 1'b0;
    end
  end

  // Cycle-by-cycle comparison of the WIDTH=8 instance against the model.
  always @(negedge CLK) begin
    if (chk_en) begin
      checks = checks + 3;
      if (out !== m_out) begin
        errors = errors + 1;
        $display("FAIL model_out: got %h expected %h at cycle %0d", out, m_out, cyc);
      end
      if (out_valid !== m_valid) begin
        errors = errors + 1;
        $display("FAIL model_valid: got %b expected %b at cycle %0d", out_valid, m_valid, cyc);
      end
      if (busy !== m_busy) begin
        errors = errors + 1;
        $display("FAIL model_busy: got %b expected %b at cycle %0d", busy, m_busy, cyc);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called just after a negedge; the following edge samples the request.
  task automatic issue(input logic s, input logic [7:0] a, input logic [7:0] b, output int e0);
    start     = 1'b1;
    in_signed = s;
    in_a      = a;
    in_b      = b;
    e0        = cyc;
    @(negedge CLK);
    start     = 1'b0;
    in_signed = 1'($urandom);
    in_a      = 8'($urandom);
    in_b      = 8'($urandom);
  endtask

  // Waits for the strobe (bounded); optionally throws ignored starts meanwhile.
  task automatic wait_result(input string name, input int e0, input logic [15:0] exp,
                             input int lat, input bit noise);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (noise && $urandom_range(0, 2) == 0) begin
        start = 1'b1;
        in_a  = 8'($urandom);
        in_b  = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge CLK);
      if (out_valid) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s_timeout: got no out_valid expected one within 40 cycles", name);
    end else begin
      check({name, "_out"}, {16'h0, out}, {16'h0, exp});
      check({name, "_lat"}, cyc - 1 - e0, lat);
    end
  endtask

  task automatic dir(input string name, input logic s, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp, input int lat);
    int e0;
    issue(s, a, b, e0);
    wait_result(name, e0, exp, lat, 1'b0);
  endtask

  task automatic run16(input string name, input logic s, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input int lat);
    int  e0;
    bit  seen = 1'b0;
    start16  = 1'b1;
    signed16 = s;
    a16      = a;
    b16      = b;
    e0       = cyc;
    @(negedge CLK);
    start16  = 1'b0;
    a16      = 16'($urandom);
    b16      = 16'($urandom);
    check({name, "_busy"}, {31'h0, busy16}, 32'h1);
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge CLK);
      if (valid16) seen = 1'b1;
    end
    if (!seen) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("FAIL %s_timeout: got no out_valid expected one within 40 cycles", name);
    end else begin
      check({name, "_out"}, out16, exp);
      check({name, "_lat"}, cyc - 1 - e0, lat);
    end
  endtask

  initial begin
    int  e0;
    int  e1;
    bit  any;
    logic        rs;
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [15:0] wa;
    logic [15:0] wb;

    reset = 1'b1; start = 1'b0; in_signed = 1'b0; in_a = 8'h0; in_b = 8'h0;
    start16 = 1'b0; signed16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    repeat (3) @(negedge CLK);
    chk_en = 1'b1;
    check("rst_out", {16'h0, out}, 32'h0);
    check("rst_valid", {31'h0, out_valid}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    @(negedge CLK);

    dir("u3x9", 1'b0, 8'd3, 8'd9, 16'd27, EARLY ? 5 : 9);
    repeat (5) @(negedge CLK);
    check("hold_out", {16'h0, out}, 32'd27);
    check("hold_busy", {31'h0, busy}, 32'h0);
    check("hold_valid", {31'h0, out_valid}, 32'h0);

    dir("sm128", 1'b1, 8'h80, 8'h80, 16'd16384, 9);
    dir("s123xm7", 1'b1, 8'd123, 8'hF9, 16'hFCA3, EARLY ? 4 : 9);
    dir("u255", 1'b0, 8'hFF, 8'hFF, 16'd65025, 9);
    dir("u10x0", 1'b0, 8'd10, 8'd0, 16'd0, EARLY ? 1 : 9);
    dir("u1x60", 1'b0, 8'd1, 8'd60, 16'd60, EARLY ? 7 : 9);
    dir("s5xm128", 1'b1, 8'd5, 8'h80, 16'hFD80, 9);

    // start during CALC with other operands must be ignored
    issue(1'b0, 8'd7, 8'd200, e0);
    @(negedge CLK);
    start = 1'b1; in_a = 8'd200; in_b = 8'd200;
    @(negedge CLK);
    start = 1'b0;
    wait_result("busy_start", e0, 16'd1400, 9, 1'b0);

    // start in the DONE cycle is accepted
    issue(1'b0, 8'd12, 8'd34, e0);
    wait_result("b2b_first", e0, 16'd408, EARLY ? 7 : 9, 1'b0);
    issue(1'b1, 8'hFD, 8'd100, e1);
    wait_result("b2b_second", e1, 16'hFED4, EARLY ? 8 : 9, 1'b0);

    // reset in the middle of an operation
    issue(1'b0, 8'd50, 8'd60, e0);
    while (cyc < e0 + 4) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    check("abort_out", {16'h0, out}, 32'h0);
    check("abort_valid", {31'h0, out_valid}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    reset = 1'b0;
    any = 1'b0;
    repeat (12) begin
      @(negedge CLK);
      if (out_valid) any = 1'b1;
    end
    check("abort_no_pulse", {31'h0, any}, 32'h0);
    dir("after_abort", 1'b0, 8'd6, 8'd7, 16'd42, EARLY ? 4 : 9);

    // randomized operations, some back-to-back, with ignored starts while busy
    for (int n = 0; n < 150; n++) begin
      rs = 1'($urandom);
      ra = 8'($urandom);
      rb = (n % 10 == 0) ? 8'h00 : 8'($urandom);
      issue(rs, ra, rb, e0);
      wait_result("rand", e0, ref_prod8(rs, ra, rb), ref_lat(mag8(rs, rb), 8), 1'b1);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge CLK);
    end

    // WIDTH=16 corners and a few random operations
    run16("w16_s_min", 1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, EARLY ? 16 : 17);
    run16("w16_u_max", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17);
    for (int n = 0; n < 6; n++) begin
      rs = 1'($urandom);
      wa = 16'($urandom);
      wb = 16'($urandom);
      run16("w16_rand", rs, wa, wb, ref_prod16(rs, wa, wb), ref_lat(mag16(rs, wb), 16));
      @(negedge CLK);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
# seq_mult

Parametrised sequential radix-2 shift-add multiplier with start/busy handshake and per-operation signed/unsigned mode. It is the next generation of the lab multiplier: operand width is a parameter, and results carry a one-cycle valid strobe. It sits as a standalone arithmetic unit driven by a controller or bench that issues one operation at a time.

## Interface
- WIDTH, 8, operand width in bits (≥2); result width is 2*WIDTH

- CLK  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; accepted on a rising edge when busy==0
- in_signed  input  1  mode for this operation: 1 = two's-complement, 0 = unsigned; sampled with start
- in_a  input  WIDTH  multiplicand, sampled with start
- in_b  input  WIDTH  multiplier, sampled with start
- out  output  2*WIDTH  product; holds last result until the next result is registered
- out_valid  output  1  one-cycle strobe, high the cycle out is updated
- busy  output  1  high while an operation is in progress

## Operation
- Reset (sync, active-high): state IDLE, out=0, out_valid=0, busy=0, internal registers cleared. Reset in any state aborts the operation; no result is produced.
- States: IDLE, CALC, DONE.
- IDLE: busy=0. start=1 at an edge: capture mode; capture |in_a| and |in_b| as WIDTH-bit unsigned magnitudes (signed mode), or the raw operands (unsigned mode). Store result sign = a[MSB]^b[MSB] (signed mode) or 0. Clear the accumulator and count, then go to CALC.
- CALC: busy=1. At each edge, if multiplier LSB=1, add the multiplicand to the accumulator. Shift the multiplicand left, shift the multiplier right, and increment count.
- CALC exit: after WIDTH iterations, the next edge registers out = sign ? −acc : acc, sets out_valid=1, and goes to DONE.
- DONE: busy=0, out_valid=1 for this cycle only. The next edge returns to IDLE with out_valid=0. A start sampled at that edge is accepted exactly as in IDLE, so back-to-back operations are possible.
- start while busy=1 is ignored. Changes on in_a, in_b and in_signed while busy=1 are ignored.
- Arithmetic: the most-negative signed operand has magnitude 2^(WIDTH−1), which fits in WIDTH unsigned bits. Every signed product fits in 2*WIDTH signed bits, and every unsigned product fits in 2*WIDTH unsigned bits. There is no overflow and no saturation. The accumulator is 2*WIDTH bits.
- Zero operands use the normal path; the result is 0 with sign ignored, so −0 is never produced.

## Timing
- Let E0 be the edge that samples start=1.
- Iterations happen at E0+1 … E0+WIDTH. out and out_valid are registered at E0+WIDTH+1, giving a latency of WIDTH+1 edges.
- busy is high from after E0 until after E0+WIDTH+1.
- out_valid is high only between E0+WIDTH+1 and E0+WIDTH+2.
- Minimum start-to-start spacing is WIDTH+2 edges.

## Configuration
- SEQ_MULT_EARLY_TERM_EN defined: in CALC, any edge at which the remaining multiplier is zero registers the result instead of iterating.
  - Latency = 1 if |b|==0.
  - Otherwise latency = msb_index(|b|)+2, with a maximum of WIDTH+1.
  - All other handshake rules are unchanged.
- Not defined: latency is always WIDTH+1.

## Structure
- Shared package/include seq_mult_pkg:
  - state encodings IDLE/CALC/DONE
  - default WIDTH
  - count width macro clog2(WIDTH+1)
- One sub-module, seq_mult_mag: combinational conditional two's-complement (magnitude of an operand when signed and negative; negate on the final result). It is instantiated for in_a, for in_b, and for the result.

## Test plan
- WIDTH=8, unsigned, 3*9 -> out=27; out_valid exactly 9 edges after E0, high for 1 cycle; busy low afterwards; out holds 27 until the next result.
- Signed -128*-128 -> out=16384. Signed 123*-7 -> out=-861 (16'hFCA3). Unsigned 255*255 -> out=65025.
- start re-asserted during CALC with different operands -> ignored; the original product is delivered at the original time. start in the DONE cycle -> accepted; the second result arrives WIDTH+1 edges later.
- reset asserted at E0+4 -> next cycle out=0, out_valid=0, busy=0; no out_valid pulse follows; a new start works normally.
- SEQ_MULT_EARLY_TERM_EN defined:
  - unsigned 10*0 -> out=0, latency 1
  - unsigned 1*60 -> out=60, latency 7
  - signed 5*-128 -> out=-640, latency 9
- SEQ_MULT_EARLY_TERM_EN undefined: 1*60 -> latency 9.
- WIDTH=16, signed -32768*32767 -> out=-1073709056; latency 17.
